// File: rtl/dfm_pkg.sv
// Shared types and defaults for the frequency-measurement block: scheduler state,
// tagged result record and default timing constants.
package dfm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StOutput
  } sched_state_t;

  // Channel tag is sized for the largest supported channel count (16).
  localparam int unsigned ChTagW = 4;

  typedef struct packed {
    logic              timeout;
    logic [ChTagW-1:0] ch;
    logic [63:0]       data;
  } sched_result_t;

  localparam int unsigned DefaultSettleCycles  = 16;
  localparam logic [31:0] DefaultTimeoutCycles = 32'h0400_0000;
  localparam logic [31:0] DefaultGateTime      = 32'd10_000_000;

endpackage

// File: rtl/ch_next.sv
// Combinational next-enabled-channel finder: lowest mask bit above cur_i, else the
// lowest set bit overall with wrap_o raised.
module ch_next #(
  parameter int unsigned CH_NUM = 4,
  localparam int unsigned ChW = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] mask_i,
  input  logic [ChW-1:0]    cur_i,
  output logic [ChW-1:0]    nxt_o,
  output logic              wrap_o
);

  logic [ChW-1:0] lo_idx, hi_idx;
  logic           lo_found, hi_found;

  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    lo_found = 1'b0;
    hi_found = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (mask_i[i] && !lo_found) begin
        lo_idx   = ChW'(i);
        lo_found = 1'b1;
      end
      if (mask_i[i] && !hi_found && (ChW'(i) > cur_i)) begin
        hi_idx   = ChW'(i);
        hi_found = 1'b1;
      end
    end
  end

  assign wrap_o = ~hi_found;
  assign nxt_o  = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/measure_sched.sv
// Measurement scheduler: walks the latched channel mask, settles and releases the shared
// datapath per channel, and presents tagged results. Watchdog under MEASURE_SCHED_TIMEOUT_EN.
module measure_sched import dfm_pkg::*; #(
  parameter int unsigned CH_NUM         = 4,
  parameter int unsigned SETTLE_CYCLES  = DefaultSettleCycles,
  parameter logic [31:0] TIMEOUT_CYCLES = DefaultTimeoutCycles,
  localparam int unsigned ChW = $clog2(CH_NUM)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              cont_i,
  input  logic [CH_NUM-1:0] ch_mask_i,
  input  logic [CH_NUM-1:0] sig_clk_i,
  output logic              sig_clk_o,
  output logic              meas_rst_n_o,
  input  logic              meas_wr_en_i,
  input  logic [63:0]       meas_wr_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [63:0]       res_data_o,
  output logic [ChW-1:0]    res_ch_o,
  output logic              res_timeout_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned    SetW    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

  if (CH_NUM < 2 || CH_NUM > 16 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES == '0) begin : g_param_chk
    $error("measure_sched: parameter out of range");
  end

  sched_state_t      state_q;
  logic [CH_NUM-1:0] mask_q;
  logic [ChW-1:0]    sel_q;
  logic [SetW-1:0]   set_cnt_q;
  logic              meas_rst_n_q;
  logic              valid_q;
  logic              done_q;
  logic              stop_pend_q;
  sched_result_t     res_q;

  logic [ChW-1:0] first_ch, nxt_ch;
  logic           unused_first_wrap, nxt_wrap;

  // First instance looks above the top index, so it always wraps to the lowest set bit.
  ch_next #(.CH_NUM(CH_NUM)) u_first (
    .mask_i (ch_mask_i),
    .cur_i  (ChW'(CH_NUM - 1)),
    .nxt_o  (first_ch),
    .wrap_o (unused_first_wrap)
  );

  ch_next #(.CH_NUM(CH_NUM)) u_next (
    .mask_i (mask_q),
    .cur_i  (sel_q),
    .nxt_o  (nxt_ch),
    .wrap_o (nxt_wrap)
  );

`ifdef MEASURE_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      sel_q        <= '0;
      set_cnt_q    <= '0;
      meas_rst_n_q <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      res_q        <= '0;
`ifdef MEASURE_SCHED_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && |ch_mask_i && !stop_i) begin
            mask_q    <= ch_mask_i;
            sel_q     <= first_ch;
            set_cnt_q <= '0;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (stop_i) begin
            state_q <= StIdle;
          end else if (set_cnt_q == SetLast) begin
            state_q      <= StMeasure;
            meas_rst_n_q <= 1'b1;
`ifdef MEASURE_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
          end else begin
            set_cnt_q <= set_cnt_q + 1'b1;
          end
        end
        StMeasure: begin
          if (stop_i) begin
            state_q      <= StIdle;
            meas_rst_n_q <= 1'b0;
          end else if (meas_wr_en_i) begin
            res_q   <= '{timeout: 1'b0, ch: ChTagW'(sel_q), data: meas_wr_data_i};
            valid_q <= 1'b1;
            state_q <= StOutput;
          end
`ifdef MEASURE_SCHED_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYCLES) begin
            res_q   <= '{timeout: 1'b1, ch: ChTagW'(sel_q), data: 64'd0};
            valid_q <= 1'b1;
            state_q <= StOutput;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
`endif
        end
        StOutput: begin
          if (stop_i) stop_pend_q <= 1'b1;
          if (res_ready_i) begin
            valid_q      <= 1'b0;
            stop_pend_q  <= 1'b0;
            sel_q        <= nxt_ch;
            meas_rst_n_q <= 1'b0;
            if (stop_i || stop_pend_q) begin
              state_q <= StIdle;
            end else if (nxt_wrap && !cont_i) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              set_cnt_q <= '0;
              state_q   <= StSettle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sig_clk_o    = sig_clk_i[sel_q];
  assign meas_rst_n_o = meas_rst_n_q;
  assign res_valid_o  = valid_q;
  assign res_data_o   = res_q.data;
  assign res_ch_o     = res_q.ch[ChW-1:0];
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;

`ifdef MEASURE_SCHED_TIMEOUT_EN
  assign res_timeout_o = res_q.timeout;
`else
  assign res_timeout_o = 1'b0;
`endif

  // Tag field is wider than needed for small CH_NUM.
  logic unused_res;
  assign unused_res = ^{res_q.ch, res_q.timeout};

endmodule

// File: tb/tb_measure_sched.sv
// Randomized self-checking bench for measure_sched; the bench plays the datapath and
// predicts channel order, timing and payload from the mask and handshake rules.
module tb_measure_sched;

  localparam int unsigned ChNum  = 4;
  localparam int unsigned Settle = 16;
  localparam logic [31:0] TbTimeout = 32'd100;

  logic        clk = 1'b0;
  logic        rst, start, stop, cont;
  logic [3:0]  mask, sig;
  logic        sig_out, meas_rst_n, wr_en;
  logic [63:0] wr_data;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [1:0]  res_ch;
  logic        res_timeout, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  measure_sched #(
    .CH_NUM         (ChNum),
    .SETTLE_CYCLES  (Settle),
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stop_i         (stop),
    .cont_i         (cont),
    .ch_mask_i      (mask),
    .sig_clk_i      (sig),
    .sig_clk_o      (sig_out),
    .meas_rst_n_o   (meas_rst_n),
    .meas_wr_en_i   (wr_en),
    .meas_wr_data_i (wr_data),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_ch_o       (res_ch),
    .res_timeout_o  (res_timeout),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles of datapath reset before release; bounded.
  task automatic wait_release(output int n);
    n = 0;
    while (meas_rst_n !== 1'b1 && n < int'(Settle) + 10) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, res_valid, 0);
    check_eq({tag, "_data"}, res_data, 0);
    check_eq({tag, "_ch"}, res_ch, 0);
    check_eq({tag, "_tmo"}, res_timeout, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_mrst"}, meas_rst_n, 0);
  endtask

  task automatic do_channel(input int exp_ch, input int delay, input logic [63:0] data,
                            input bit exp_done, input int stall);
    int n;
    wait_release(n);
    check_eq("settle_len", n, Settle);
    check_eq("busy_meas", busy, 1);
    check_eq("valid_meas", res_valid, 0);
    sig = 4'($urandom);
    #1;
    check_eq("sig_sel", sig_out, sig[exp_ch]);
    repeat (delay) tick();
    check_eq("valid_before_strobe", res_valid, 0);
    wr_data = data;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    wr_data = {$urandom, $urandom};
    check_eq("valid_rise", res_valid, 1);
    check_eq("res_data", res_data, data);
    check_eq("res_ch", res_ch, exp_ch);
    check_eq("res_tmo", res_timeout, 0);
    if (stall > 0) begin
      repeat (stall / 2) tick();
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      repeat (stall - stall / 2) tick();
      check_eq("stall_valid", res_valid, 1);
      check_eq("stall_data", res_data, data);
      check_eq("stall_ch", res_ch, exp_ch);
      check_eq("stall_done", done, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("valid_drop", res_valid, 0);
    check_eq("done_pulse", done, exp_done);
    check_eq("busy_after", busy, !exp_done);
    if (exp_done) begin
      tick();
      check_eq("done_width", done, 0);
    end
  endtask

  task automatic run_scan(input logic [3:0] m, input bit c, input int passes, input bit fixed);
    int  chs[$];
    bit  last;
    for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(i);
    mask  = m;
    cont  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    mask  = 4'($urandom);
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < chs.size(); k++) begin
        last = (k == chs.size() - 1) && (p == passes - 1) && !c;
        if (fixed) do_channel(chs[k], 50, 64'h0000_0064_0000_000A, last, 20);
        else do_channel(chs[k], int'($urandom_range(0, 60)), {$urandom, $urandom}, last,
                        int'($urandom_range(0, 8)));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog");
  end

  initial begin
    int n;
    logic [3:0] m;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = '0; sig = '0;
    wr_en = 1'b0; wr_data = '0; res_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed scan of channels 1 and 3.
    run_scan(4'b1010, 1'b0, 1, 1'b1);

    // Empty mask ignores start.
    mask  = 4'b0000;
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    check_eq("zmask_busy", busy, 0);
    check_eq("zmask_mrst", meas_rst_n, 0);
    check_eq("zmask_valid", res_valid, 0);

    // Random single scans.
    for (int it = 0; it < 10; it++) begin
      m = 4'($urandom_range(1, 15));
      run_scan(m, 1'b0, 1, 1'b0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    // Stop five cycles into MEASURE.
    mask = 4'b0110; start = 1'b1;
    tick();
    start = 1'b0;
    wait_release(n);
    check_eq("stopm_settle", n, Settle);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stopm_busy", busy, 0);
    check_eq("stopm_mrst", meas_rst_n, 0);
    check_eq("stopm_valid", res_valid, 0);
    check_eq("stopm_done", done, 0);
    repeat (3) tick();
    check_eq("stopm_valid2", res_valid, 0);
    check_eq("stopm_done2", done, 0);

    // Stop while a result is pending: handshake completes, no done.
    mask = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    wait_release(n);
    check_eq("stopo_settle", n, Settle);
    wr_data = 64'hDEAD_BEEF_0123_4567; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stopo_valid", res_valid, 1);
    check_eq("stopo_data", res_data, 64'hDEAD_BEEF_0123_4567);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("stopo_busy", busy, 0);
    check_eq("stopo_done", done, 0);
    check_eq("stopo_vdrop", res_valid, 0);

    // Continuous single-channel scan, then asynchronous reset mid-SETTLE.
    run_scan(4'b0001, 1'b1, 3, 1'b0);
    repeat (3) tick();
    check_eq("cont_busy", busy, 1);
    check_eq("cont_mrst", meas_rst_n, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sig = 4'($urandom);
    #1;
    check_eq("rst_sig_sel", sig_out, sig[0]);
    cont = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef MEASURE_SCHED_TIMEOUT_EN
    // Watchdog expiry, then strobe coinciding with expiry.
    mask = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    wait_release(n);
    check_eq("tmo_settle", n, Settle);
    n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check_eq("tmo_latency", n, int'(TbTimeout) + 1);
    check_eq("tmo_flag", res_timeout, 1);
    check_eq("tmo_data", res_data, 0);
    check_eq("tmo_ch", res_ch, 2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("tmo_done", done, 1);

    mask = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    wait_release(n);
    repeat (int'(TbTimeout)) tick();
    wr_data = 64'h0000_0064_0000_000A; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check_eq("tie_valid", res_valid, 1);
    check_eq("tie_flag", res_timeout, 0);
    check_eq("tie_data", res_data, 64'h0000_0064_0000_000A);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("tie_done", done, 1);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
